// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// operation width and default latencies.
package md_pkg;

    localparam int unsigned MD_OP_W = 3;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    // Code 7 is unused and treated like MD_NONE.
    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic md_is_multi(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // True for the divide operations (selects DIV latency and result format).
    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational datapath of the multiply/divide unit. Produces the HI/LO
// result pair for the latched operation and flags a divide by zero.
module md_core
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op_i,
    input  logic [31:0]        a_i,
    input  logic [31:0]        b_i,
    output logic [31:0]        hi_o,
    output logic [31:0]        lo_o,
    output logic               div_zero_o
);

    logic        is_signed;
    logic        is_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Sign-magnitude datapath shared by signed and unsigned variants; the
    // result sign is reapplied at the end. |0x80000000| is 0x80000000 as an
    // unsigned value, so the 0x80000000 / -1 corner falls out naturally.
    always_comb begin
        is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
        is_div    = md_is_div(op_i);
        a_neg     = is_signed & a_i[31];
        b_neg     = is_signed & b_i[31];
        a_mag     = a_neg ? (~a_i + 32'd1) : a_i;
        b_mag     = b_neg ? (~b_i + 32'd1) : b_i;

        prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
        prod      = (a_neg ^ b_neg) ? (~prod_mag + 64'd1) : prod_mag;

        // Substitute a divisor of 1 on zero so the divider never sees x/0.
        div_zero_o = is_div & (b_i == 32'd0);
        divisor    = (b_i == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / divisor;
        r_mag      = a_mag % divisor;
        quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

        if (is_div) begin
            hi_o = rem;
            lo_o = quot;
        end else begin
            hi_o = prod[63:32];
            lo_o = prod[31:0];
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Optional feature: define MD_CANCEL_EN to add the cancel (pipeline flush)
// input, which aborts a running operation without touching HI/LO.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
`ifdef MD_CANCEL_EN
    input  logic               cancel,
`endif
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic               busy,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam int unsigned MaxLat = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [MD_OP_W-1:0]  op_q;
    logic [31:0]         a_q;
    logic [31:0]         b_q;
    logic [31:0]         hi_q;
    logic [31:0]         lo_q;
    logic                busy_q;

    logic                cancel_w;
    logic [31:0]         res_hi;
    logic [31:0]         res_lo;
    logic                res_div_zero;

`ifdef MD_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    md_core u_core (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .hi_o       (res_hi),
        .lo_o       (res_lo),
        .div_zero_o (res_div_zero)
    );

    // Control FSM, latency counter, operand latches and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A flush in the same cycle blocks every kind of accept.
                    if (start && !cancel_w) begin
                        if (md_is_multi(md_op)) begin
                            op_q    <= md_op;
                            a_q     <= a;
                            b_q     <= b;
                            cnt_q   <= md_is_div(md_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                            busy_q  <= 1'b1;
                            state_q <= StRun;
                        end else if (md_op == MD_MTHI) begin
                            hi_q <= a;
                        end else if (md_op == MD_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                StRun: begin
                    // New starts are ignored here; stall logic keeps them away.
                    if (cancel_w) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_q == CntW'(1)) begin
                        if (!res_div_zero) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed HI/LO values.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cancel;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fails  = 0;

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MD_CANCEL_EN
        .cancel(cancel),
`endif
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; inputs/outputs are touched 1ns after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a one-cycle start request.
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        md_op = op;
        a     = av;
        b     = bv;
        step(1);
        start = 1'b0;
        md_op = 3'd0;
    endtask

    // After an accepted multi-cycle op: busy for lat cycles, low on the update edge.
    task automatic run_out(input int lat, input string tag);
        chk({tag, " busy@1"}, {31'd0, busy}, 32'd1);
        step(lat - 1);
        chk({tag, " busy@last"}, {31'd0, busy}, 32'd1);
        step(1);
        chk({tag, " busy done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        cancel = 1'b0;
        start  = 1'b0;
        md_op  = 3'd0;
        a      = 32'd0;
        b      = 32'd0;
        step(2);
        reset = 1'b0;
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy", {31'd0, busy}, 32'd0);

        // MULT -3 * 5, operands scrambled during RUN.
        issue(3'd1, 32'hFFFF_FFFD, 32'd5);
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        chk("mult hi held", hi, 32'h0);
        run_out(5, "mult");
        chk("mult hi", hi, 32'hFFFF_FFFF);
        chk("mult lo", lo, 32'hFFFF_FFF1);

        // MULTU all-ones squared, issued in the first idle cycle.
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_out(5, "multu");
        chk("multu hi", hi, 32'hFFFF_FFFE);
        chk("multu lo", lo, 32'h0000_0001);

        // DIV -7 / 2.
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        run_out(10, "div");
        chk("div lo", lo, 32'hFFFF_FFFD);
        chk("div hi", hi, 32'hFFFF_FFFF);

        // DIVU by zero: full busy period, HI/LO untouched.
        issue(3'd4, 32'd7, 32'd0);
        run_out(10, "divu0");
        chk("divu0 lo", lo, 32'hFFFF_FFFD);
        chk("divu0 hi", hi, 32'hFFFF_FFFF);

        // DIV 7 / -2: quotient -3, remainder +1.
        issue(3'd3, 32'd7, 32'hFFFF_FFFE);
        step(10);
        chk("div neg divisor lo", lo, 32'hFFFF_FFFD);
        chk("div neg divisor hi", hi, 32'h0000_0001);

        // DIV overflow corner.
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        step(10);
        chk("div ovf lo", lo, 32'h8000_0000);
        chk("div ovf hi", hi, 32'h0);

        // DIVU large unsigned.
        issue(3'd4, 32'hFFFF_FFFF, 32'h10);
        step(10);
        chk("divu lo", lo, 32'h0FFF_FFFF);
        chk("divu hi", hi, 32'h0000_000F);

        // MULT 6*7 with a DIV and an MTHI arriving during RUN.
        issue(3'd1, 32'd6, 32'd7);
        step(1);
        issue(3'd3, 32'd100, 32'd3);
        issue(3'd5, 32'h1234, 32'd0);
        chk("overlap hi held", hi, 32'h0000_000F);
        step(1);
        chk("overlap busy@4", {31'd0, busy}, 32'd1);
        chk("overlap lo held", lo, 32'h0FFF_FFFF);
        step(1);
        chk("overlap busy done", {31'd0, busy}, 32'd0);
        chk("overlap hi", hi, 32'h0);
        chk("overlap lo", lo, 32'h2A);
        step(10);
        chk("overlap late busy", {31'd0, busy}, 32'd0);
        chk("overlap late hi", hi, 32'h0);
        chk("overlap late lo", lo, 32'h2A);

        // MTLO / MTHI in idle: zero latency, never busy.
        issue(3'd6, 32'hCAFE_BABE, 32'd0);
        chk("mtlo lo", lo, 32'hCAFE_BABE);
        chk("mtlo busy", {31'd0, busy}, 32'd0);
        chk("mtlo hi", hi, 32'h0);
        issue(3'd5, 32'h55, 32'd0);
        chk("mthi hi", hi, 32'h55);
        chk("mthi lo", lo, 32'hCAFE_BABE);

        // NONE and unused code 7: no effect.
        issue(3'd0, 32'hDEAD, 32'd1);
        issue(3'd7, 32'hDEAD, 32'd1);
        chk("nop busy", {31'd0, busy}, 32'd0);
        chk("nop hi", hi, 32'h55);
        chk("nop lo", lo, 32'hCAFE_BABE);

        // Reset in the middle of a DIV discards it.
        issue(3'd3, 32'd100, 32'd3);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst mid hi", hi, 32'h0);
        chk("rst mid lo", lo, 32'h0);
        chk("rst mid busy", {31'd0, busy}, 32'd0);
        step(12);
        chk("rst late lo", lo, 32'h0);
        chk("rst late busy", {31'd0, busy}, 32'd0);

`ifdef MD_CANCEL_EN
        // DIV cancelled at cycle 4.
        issue(3'd3, 32'd9, 32'd2);
        step(3);
        cancel = 1'b1;
        step(1);
        cancel = 1'b0;
        chk("cancel busy", {31'd0, busy}, 32'd0);
        chk("cancel lo", lo, 32'h0);
        step(10);
        chk("cancel late lo", lo, 32'h0);
        chk("cancel late hi", hi, 32'h0);
        // Cancel in the start cycle blocks MTHI.
        cancel = 1'b1;
        issue(3'd5, 32'd77, 32'd0);
        cancel = 1'b0;
        chk("cancel blocks mthi", hi, 32'h0);
        issue(3'd1, 32'd2, 32'd3);
        run_out(5, "post-cancel mult");
        chk("post-cancel lo", lo, 32'd6);
        chk("post-cancel hi", hi, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
